// File: rtl/cic_sample_fifo.sv
// Output stage behind the CIC decimator: scales each captured sample by a runtime right shift with
// unsigned saturation, then buffers it in a first-word-fall-through FIFO with a valid/ready drain.
module cic_sample_fifo #(
   parameter int unsigned IN_W       = 32,
   parameter int unsigned OUT_W      = 16,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       in_data,
   input  logic                  in_rdy,
   input  logic [4:0]            shift,
   output logic [OUT_W-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clr_ovf
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;

   logic [IN_W-1:0]  shifted;
   logic [OUT_W-1:0] scaled;

   logic [OUT_W-1:0] stg_q;
   logic             stg_vld_q;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;

   logic [OUT_W-1:0] mem [DEPTH];

   logic             full, empty, push, pop, drop;

   // Any bit set above the output width means the value does not fit: clamp to all ones.
   assign shifted = in_data >> shift;
   assign scaled  = (|shifted[IN_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_q     <= '0;
         stg_vld_q <= 1'b0;
      end else begin
         stg_vld_q <= in_rdy;
         if (in_rdy) begin
            stg_q <= scaled;
         end
      end
   end

   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // A pop on the same edge frees the head slot, so a full FIFO can still accept the write.
   assign pop  = !empty && m_ready;
   assign push = stg_vld_q && (!full || pop);
   assign drop = stg_vld_q && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + PW'(1);
         2'b01:   level_d = level_q - PW'(1);
         default: level_d = level_q;
      endcase
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[PW-2:0]] <= stg_q;
      end
   end

   // Gate the head so reset and empty present zero instead of stale memory.
   assign m_valid  = !empty;
   assign m_data   = empty ? '0 : mem[rd_ptr_q[PW-2:0]];
   assign level    = level_q;
   assign overflow = ovf_q;

endmodule
